// File: rtl/enc_pkg.sv
// Shared definitions for the rotary encoder front end: detent code, phase type,
// quadrature move classification and constant-width helpers.
package enc_pkg;

  localparam logic [1:0] DETENT = 2'b11;

  typedef logic signed [2:0] phase_t;

  // +4 and -4 share this 3-bit pattern; the move direction tells them apart.
  localparam phase_t PHASE_FULL = 3'sd4;

  // Quarter-turn difference between two quadrature samples, modulo 4.
  typedef enum logic [1:0] {
    MV_HOLD    = 2'd0,
    MV_CW      = 2'd1,
    MV_ILLEGAL = 2'd2,
    MV_CCW     = 2'd3
  } move_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'(1) << i) < 33'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Angular position of an A/B code, counting CW quarter turns from the detent.
  function automatic logic [1:0] enc_pos(input logic [1:0] ab);
    logic [1:0] p;
    case (ab)
      2'b11:   p = 2'd0;
      2'b01:   p = 2'd1;
      2'b00:   p = 2'd2;
      default: p = 2'd3;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rotary_enc_counter_if.sv
// Pin-side and position-side signals of the rotary encoder counter.
interface rotary_enc_counter_if #(
  parameter int unsigned CNT_W = 8
);

  logic             enc_a;
  logic             enc_b;
  logic             enc_btn;
  logic             clr;
  logic [CNT_W-1:0] count;
  logic             dir;
  logic             step;
  logic             btn_level;
  logic             btn_press;
  logic             err;

  modport master (
    output enc_a, enc_b, enc_btn, clr,
    input  count, dir, step, btn_level, btn_press, err
  );

  modport slave (
    input  enc_a, enc_b, enc_btn, clr,
    output count, dir, step, btn_level, btn_press, err
  );

endinterface

// File: rtl/enc_debounce.sv
// Two-flop synchroniser followed by a stable-count filter; the output only
// follows the input after DEB_CYCLES consecutive differing samples.
module enc_debounce
  import enc_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 50000,
  parameter logic        RST_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic deb_o
);

  localparam int unsigned CW       = (clog2(DEB_CYCLES) < 1) ? 1 : clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q,   deb_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // Count while the synchronised level disagrees; adopt it on the last count.
  always_comb begin
    sync1_d = raw_i;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      deb_q   <= RST_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/rotary_enc_counter.sv
// Rotary encoder front end: debounced A/B/button, full-detent decoding and a
// bounded position counter. Define ENC_WRAP_EN to wrap instead of saturate.
module rotary_enc_counter
  import enc_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned MAX_VAL    = 120,
  parameter int unsigned INIT_VAL   = 0,
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  rotary_enc_counter_if.slave  bus
);

`ifdef ENC_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] INIT_C = CNT_W'(INIT_VAL);

  logic deb_a, deb_b, deb_btn;

  enc_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb_a (
    .clk(clk), .rst(rst), .raw_i(bus.enc_a), .deb_o(deb_a)
  );

  enc_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_deb_b (
    .clk(clk), .rst(rst), .raw_i(bus.enc_b), .deb_o(deb_b)
  );

  enc_debounce #(.DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_deb_btn (
    .clk(clk), .rst(rst), .raw_i(bus.enc_btn), .deb_o(deb_btn)
  );

  logic [1:0]       ab_c;
  move_e            move_c;
  phase_t           phase_nxt_c;
  logic             commit_cw_c, commit_ccw_c;

  logic [1:0]       ab_prev_q,   ab_prev_d;
  phase_t           phase_q,     phase_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic             dir_q,       dir_d;
  logic             step_q,      step_d;
  logic             err_q,       err_d;
  logic             btn_prev_q,  btn_prev_d;
  logic             btn_press_q, btn_press_d;

  assign ab_c   = {deb_a, deb_b};
  assign move_c = move_e'(2'(enc_pos(ab_c) - enc_pos(ab_prev_q)));

  // Quadrature decode: track phase since the last detent, commit on re-entry.
  always_comb begin
    phase_nxt_c  = phase_q;
    commit_cw_c  = 1'b0;
    commit_ccw_c = 1'b0;
    err_d        = 1'b0;
    case (move_c)
      MV_CW:      phase_nxt_c = phase_q + phase_t'(1);
      MV_CCW:     phase_nxt_c = phase_q - phase_t'(1);
      MV_ILLEGAL: begin
        err_d       = 1'b1;
        phase_nxt_c = '0;
      end
      default:    phase_nxt_c = phase_q;
    endcase
    phase_d = phase_nxt_c;
    if ((move_c == MV_CW || move_c == MV_CCW) && ab_c == DETENT) begin
      phase_d      = '0;
      commit_cw_c  = (move_c == MV_CW)  && (phase_nxt_c == PHASE_FULL);
      commit_ccw_c = (move_c == MV_CCW) && (phase_nxt_c == PHASE_FULL);
    end
    ab_prev_d = ab_c;
  end

  // Bounded position counter, step/dir reporting and button edge pulse.
  always_comb begin
    count_d     = count_q;
    dir_d       = dir_q;
    step_d      = commit_cw_c | commit_ccw_c;
    btn_prev_d  = deb_btn;
    btn_press_d = deb_btn & ~btn_prev_q;
    if (commit_cw_c) begin
      dir_d = 1'b1;
      if (count_q >= MAX_C) begin
        count_d = WRAP_EN ? '0 : MAX_C;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (commit_ccw_c) begin
      dir_d = 1'b0;
      if (count_q == '0) begin
        count_d = WRAP_EN ? MAX_C : '0;
      end else begin
        count_d = count_q - CNT_W'(1);
      end
    end
    if (bus.clr) begin
      count_d = INIT_C;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ab_prev_q   <= DETENT;
      phase_q     <= '0;
      count_q     <= INIT_C;
      dir_q       <= 1'b0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
      btn_prev_q  <= 1'b0;
      btn_press_q <= 1'b0;
    end else begin
      ab_prev_q   <= ab_prev_d;
      phase_q     <= phase_d;
      count_q     <= count_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      err_q       <= err_d;
      btn_prev_q  <= btn_prev_d;
      btn_press_q <= btn_press_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.dir       = dir_q;
  assign bus.step      = step_q;
  assign bus.err       = err_q;
  assign bus.btn_level = deb_btn;
  assign bus.btn_press = btn_press_q;

endmodule

// File: tb/tb_rotary_enc_counter.sv
// Bench for rotary_enc_counter: directed quadrature/button stimulus, a
// window-based reference model checked every cycle, plus literal expectations.
module tb_rotary_enc_counter;

  localparam int DEB   = 4;
  localparam int MAXV  = 120;
  localparam int INITV = 0;
  localparam int H     = 10;
`ifdef ENC_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk;
  logic rst;

  rotary_enc_counter_if #(.CNT_W(8)) bus ();

  rotary_enc_counter #(
    .CNT_W(8), .MAX_VAL(MAXV), .INIT_VAL(INITV), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: raw sample history, level adopted once the delayed window agrees.
  bit ha[DEB+2];
  bit hb[DEB+2];
  bit hbtn[DEB+2];
  bit m_a, m_b, m_btn, m_btn_prev;
  bit [1:0] m_prev_ab;
  int m_phase, m_count;
  bit m_dir, m_step, m_err, m_press;
  bit m_valid = 1'b0;

  function automatic int quad(input bit [1:0] ab);
    case (ab)
      2'b11:   return 0;
      2'b01:   return 1;
      2'b00:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic bit settle(input bit h[DEB+2], input bit cur);
    bit flip;
    flip = 1'b1;
    for (int i = 2; i < DEB + 2; i++) if (h[i] == cur) flip = 1'b0;
    return flip ? ~cur : cur;
  endfunction

  always @(posedge clk) begin
    bit [1:0] cur;
    int d;
    bit cw, ccw;
    if (rst) begin
      for (int i = 0; i < DEB + 2; i++) begin
        ha[i] = 1'b1; hb[i] = 1'b1; hbtn[i] = 1'b0;
      end
      m_a = 1'b1; m_b = 1'b1; m_btn = 1'b0; m_btn_prev = 1'b0;
      m_prev_ab = 2'b11; m_phase = 0; m_count = INITV;
      m_dir = 1'b0; m_step = 1'b0; m_err = 1'b0; m_press = 1'b0;
    end else begin
      cur = {m_a, m_b};
      d = (quad(cur) - quad(m_prev_ab) + 4) % 4;
      cw = 1'b0; ccw = 1'b0; m_step = 1'b0; m_err = 1'b0;
      if (d == 2) begin
        m_err = 1'b1; m_phase = 0;
      end else if (d == 1) m_phase = m_phase + 1;
      else if (d == 3) m_phase = m_phase - 1;
      if ((d == 1 || d == 3) && cur == 2'b11) begin
        cw  = (m_phase == 4);
        ccw = (m_phase == -4);
        m_phase = 0;
      end
      if (cw) begin
        m_step = 1'b1; m_dir = 1'b1;
        m_count = (m_count == MAXV) ? (WRAP ? 0 : MAXV) : m_count + 1;
      end
      if (ccw) begin
        m_step = 1'b1; m_dir = 1'b0;
        m_count = (m_count == 0) ? (WRAP ? MAXV : 0) : m_count - 1;
      end
      if (bus.clr) m_count = INITV;
      m_prev_ab = cur;
      m_press = m_btn && !m_btn_prev;
      m_btn_prev = m_btn;
      for (int i = DEB + 1; i > 0; i--) begin
        ha[i] = ha[i-1]; hb[i] = hb[i-1]; hbtn[i] = hbtn[i-1];
      end
      ha[0] = bus.enc_a; hb[0] = bus.enc_b; hbtn[0] = bus.enc_btn;
      m_a = settle(ha, m_a);
      m_b = settle(hb, m_b);
      m_btn = settle(hbtn, m_btn);
    end
    m_valid = 1'b1;
  end

  // Per-cycle compare plus event tallies used by the directed checks.
  int steps_seen = 0, err_seen = 0, press_seen = 0, lvl_cycles = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("count", int'(bus.count), m_count);
      chk("dir", int'(bus.dir), int'(m_dir));
      chk("step", int'(bus.step), int'(m_step));
      chk("err", int'(bus.err), int'(m_err));
      chk("btn_level", int'(bus.btn_level), int'(m_btn));
      chk("btn_press", int'(bus.btn_press), int'(m_press));
      if (bus.step) steps_seen++;
      if (bus.err) err_seen++;
      if (bus.btn_press) press_seen++;
      if (bus.btn_level) lvl_cycles++;
    end
  end

  task automatic hold(input bit a, input bit b, input int n);
    bus.enc_a = a;
    bus.enc_b = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic cw_detent();
    hold(0, 1, H); hold(0, 0, H); hold(1, 0, H); hold(1, 1, H);
  endtask

  task automatic ccw_detent();
    hold(1, 0, H); hold(0, 0, H); hold(0, 1, H); hold(1, 1, H);
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  int s0, e0;

  initial begin
    rst = 1'b1;
    bus.enc_a = 1'b1; bus.enc_b = 1'b1; bus.enc_btn = 1'b0; bus.clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_count", int'(bus.count), INITV);
    chk("reset_dir", int'(bus.dir), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: one CW detent
    s0 = steps_seen;
    cw_detent();
    #1;
    chk("t1_count", int'(bus.count), 1);
    chk("t1_dir", int'(bus.dir), 1);
    chk("t1_steps", steps_seen - s0, 1);
    pulse_clr();

    // 2: CCW at the lower bound
    s0 = steps_seen;
    ccw_detent();
    #1;
    chk("t2_count", int'(bus.count), WRAP ? 120 : 0);
    chk("t2_dir", int'(bus.dir), 0);
    chk("t2_steps", steps_seen - s0, 1);
    pulse_clr();

    // 3: 121 CW detents against the upper bound
    s0 = steps_seen;
    for (int i = 0; i < 121; i++) begin
      cw_detent();
      if (i == 119) chk("t3_count_120th", int'(bus.count), 120);
    end
    #1;
    chk("t3_count_121st", int'(bus.count), WRAP ? 0 : 120);
    chk("t3_steps", steps_seen - s0, 121);
    pulse_clr();

    // 4: short glitch, then a half rotation that backs out
    s0 = steps_seen; e0 = err_seen;
    hold(0, 1, 2); hold(1, 1, 20);
    hold(0, 1, H); hold(0, 0, H); hold(0, 1, H); hold(1, 1, H);
    #1;
    chk("t4_steps", steps_seen - s0, 0);
    chk("t4_err", err_seen - e0, 0);
    chk("t4_count", int'(bus.count), 0);

    // 5: illegal jump, then clear colliding with a commit
    s0 = steps_seen; e0 = err_seen;
    hold(0, 0, H); hold(1, 0, H); hold(1, 1, H);
    #1;
    chk("t5_err", err_seen - e0, 1);
    chk("t5_nostep", steps_seen - s0, 0);
    cw_detent();
    hold(0, 1, H); hold(0, 0, H); hold(1, 0, H);
    s0 = steps_seen;
    bus.enc_a = 1'b1; bus.enc_b = 1'b1;
    repeat (DEB + 2) @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    repeat (H) @(negedge clk);
    #1;
    chk("t5_clr_count", int'(bus.count), 0);
    chk("t5_clr_step", steps_seen - s0, 1);
    chk("t5_clr_dir", int'(bus.dir), 1);

    // 6: button press, then reset in the middle of a rotation
    e0 = press_seen;
    lvl_cycles = 0;
    bus.enc_btn = 1'b1;
    repeat (10) @(negedge clk);
    bus.enc_btn = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("t6_press", press_seen - e0, 1);
    chk("t6_level_cycles", lvl_cycles, 10);
    cw_detent();
    s0 = steps_seen; e0 = err_seen;
    hold(0, 1, H); hold(0, 0, H);
    rst = 1'b1;
    bus.enc_a = 1'b1; bus.enc_b = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("t6_rst_count", int'(bus.count), INITV);
    chk("t6_rst_dir", int'(bus.dir), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("t6_rst_steps", steps_seen - s0, 0);
    chk("t6_rst_err", err_seen - e0, 0);
    cw_detent();
    #1;
    chk("t6_after_count", int'(bus.count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
